// File: rtl/hpchn_pkg.sv
// Shared constants and state encoding for the high-priority channel arbiter.
package hpchn_pkg;

  localparam int CHN_NUM   = 16;
  localparam int CHN_MUX_W = 4;

  // One-hot-ish encoding so grant-valid and busy can be taken straight
  // from individual state register bits.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    BUSY = 2'b10
  } state_t;

endpackage

// File: rtl/hpchn_encd.sv
// One-hot to binary channel encoder. Each code bit is the OR of every
// one-hot position whose index has that bit set, so an all-zero input
// naturally yields code 0.
module hpchn_encd #(
  parameter int CHN_NUM   = hpchn_pkg::CHN_NUM,
  parameter int CHN_MUX_W = hpchn_pkg::CHN_MUX_W
) (
  input  logic [CHN_NUM-1:0]   i_onehot,
  output logic [CHN_MUX_W-1:0] o_cod
);

  // OR-reduce the one-hot positions contributing to each code bit
  always_comb begin
    o_cod = '0;
    for (int b = 0; b < CHN_MUX_W; b++) begin
      for (int i = 0; i < CHN_NUM; i++) begin
        if (((i >> b) & 1) != 0) begin
          o_cod[b] = o_cod[b] | i_onehot[i];
        end
      end
    end
  end

endmodule

// File: rtl/hpchn_arb.sv
// High-priority DMA channel arbiter: collects triggers into a pending
// register, grants the lowest-numbered pending channel and holds it
// through a valid/ack handshake until the engine signals completion.
// Every output comes straight from a register.
module hpchn_arb #(
  parameter int CHN_NUM   = hpchn_pkg::CHN_NUM,
  parameter int CHN_MUX_W = hpchn_pkg::CHN_MUX_W
) (
  input  logic                 hclk,
  input  logic                 hrst_b,
  input  logic [CHN_NUM-1:0]   chn_trg,
  input  logic [CHN_NUM-1:0]   chn_en,
  input  logic                 grnt_ack,
  input  logic                 chn_done,
  output logic                 grnt_vld,
  output logic [CHN_NUM-1:0]   grnt_onehot,
  output logic [CHN_MUX_W-1:0] grnt_chn_cod,
  output logic [CHN_NUM-1:0]   pend,
  output logic                 busy
);

  import hpchn_pkg::*;

  localparam logic [CHN_NUM-1:0] ONE_VEC = {{(CHN_NUM-1){1'b0}}, 1'b1};

  state_t                 r_state;
  logic [CHN_NUM-1:0]     r_pend;
  logic [CHN_NUM-1:0]     r_onehot;
  logic [CHN_MUX_W-1:0]   r_cod;

  state_t                 w_nxt_state;
  logic [CHN_NUM-1:0]     w_nxt_onehot;
  logic [CHN_MUX_W-1:0]   w_nxt_cod;
  logic [CHN_NUM-1:0]     w_pend_nxt;
  logic [CHN_NUM-1:0]     w_sel;
  logic [CHN_MUX_W-1:0]   w_sel_cod;
  logic                   w_in_busy;
  logic [CHN_NUM-1:0]     w_set;
  logic [CHN_NUM-1:0]     w_hold;
  logic [CHN_NUM-1:0]     w_clr;
  logic                   w_gnt_en;

  // Lowest set bit of the registered pending vector; triggers never bypass it
  assign w_sel = r_pend & (~r_pend + ONE_VEC);

  hpchn_encd #(
    .CHN_NUM   (CHN_NUM),
    .CHN_MUX_W (CHN_MUX_W)
  ) u_encd (
    .i_onehot (w_sel),
    .o_cod    (w_sel_cod)
  );

  assign w_in_busy = (r_state == BUSY);
  assign w_gnt_en  = |(chn_en & r_onehot);

  // Pending update: enabled triggers set, completion or disable clears,
  // set wins; the channel under transfer is immune to disable
  always_comb begin
    w_set      = chn_trg & chn_en;
    w_hold     = {CHN_NUM{w_in_busy}} & r_onehot;
    w_clr      = ({CHN_NUM{w_in_busy & chn_done}} & r_onehot) | (~chn_en & ~w_hold);
    w_pend_nxt = w_set | (r_pend & ~w_clr);
  end

  // Next-state and next grant selection; withdrawal beats a same-cycle ack
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_onehot = r_onehot;
    w_nxt_cod    = r_cod;
    case (r_state)
      IDLE: begin
        if (|r_pend) begin
          w_nxt_state  = REQ;
          w_nxt_onehot = w_sel;
          w_nxt_cod    = w_sel_cod;
        end
      end
      REQ: begin
        if (!w_gnt_en) begin
          w_nxt_state  = IDLE;
          w_nxt_onehot = '0;
          w_nxt_cod    = '0;
        end else if (grnt_ack) begin
          w_nxt_state = BUSY;
        end
      end
      BUSY: begin
        if (chn_done) begin
          w_nxt_state  = IDLE;
          w_nxt_onehot = '0;
          w_nxt_cod    = '0;
        end
      end
      default: begin
        w_nxt_state  = IDLE;
        w_nxt_onehot = '0;
        w_nxt_cod    = '0;
      end
    endcase
  end

  // State, pending and grant registers with asynchronous clear
  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      r_state  <= IDLE;
      r_pend   <= '0;
      r_onehot <= '0;
      r_cod    <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_pend   <= w_pend_nxt;
      r_onehot <= w_nxt_onehot;
      r_cod    <= w_nxt_cod;
    end
  end

  assign grnt_vld     = r_state[0];
  assign busy         = r_state[1];
  assign grnt_onehot  = r_onehot;
  assign grnt_chn_cod = r_cod;
  assign pend         = r_pend;

endmodule

// File: tb/tb_hpchn_arb.sv
// Scenario bench for hpchn_arb: expected grant channels are queued when
// triggers are driven and popped as grants appear.
module tb_hpchn_arb;

  logic        hclk;
  logic        hrst_b;
  logic [15:0] chn_trg;
  logic [15:0] chn_en;
  logic        grnt_ack;
  logic        chn_done;
  logic        grnt_vld;
  logic [15:0] grnt_onehot;
  logic [3:0]  grnt_chn_cod;
  logic [15:0] pend;
  logic        busy;

  int testsRun    = 0;
  int testsFailed = 0;
  int expQ[$];

  hpchn_arb dut (
    .hclk         (hclk),
    .hrst_b       (hrst_b),
    .chn_trg      (chn_trg),
    .chn_en       (chn_en),
    .grnt_ack     (grnt_ack),
    .chn_done     (chn_done),
    .grnt_vld     (grnt_vld),
    .grnt_onehot  (grnt_onehot),
    .grnt_chn_cod (grnt_chn_cod),
    .pend         (pend),
    .busy         (busy)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  // Consume queued grants: wait for valid, compare against the queue head,
  // then ack and complete the transfer.
  task automatic drain_grants(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      int          waitCnt;
      int          expChn;
      logic [15:0] expOh;
      waitCnt = 0;
      while (!grnt_vld && waitCnt < 20) begin
        step();
        waitCnt++;
      end
      testsRun++;
      if (grnt_vld !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL %s_wait: grnt_vld=%b after %0d cycles, required 1", tag, grnt_vld, waitCnt);
        return;
      end
      testsRun++;
      if (expQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL %s_unexpected: grant on channel %0d, none expected", tag, grnt_chn_cod);
        return;
      end
      expChn = expQ.pop_front();
      expOh  = 16'h0001 << expChn;
      if (grnt_chn_cod !== expChn[3:0] || grnt_onehot !== expOh) begin
        testsFailed++;
        $display("[TB] FAIL %s_grant: cod=%0d onehot=%h, required cod=%0d onehot=%h", tag, grnt_chn_cod, grnt_onehot, expChn, expOh);
      end
      grnt_ack = 1'b1;
      step();
      grnt_ack = 1'b0;
      testsRun++;
      if (busy !== 1'b1 || grnt_vld !== 1'b0 || grnt_onehot !== expOh) begin
        testsFailed++;
        $display("[TB] FAIL %s_ack: busy=%b vld=%b onehot=%h, required 1 0 %h", tag, busy, grnt_vld, grnt_onehot, expOh);
      end
      chn_done = 1'b1;
      step();
      chn_done = 1'b0;
      testsRun++;
      if (busy !== 1'b0 || grnt_vld !== 1'b0 || grnt_onehot !== 16'h0 || grnt_chn_cod !== 4'd0) begin
        testsFailed++;
        $display("[TB] FAIL %s_done: busy=%b vld=%b onehot=%h cod=%0d, required all zero", tag, busy, grnt_vld, grnt_onehot, grnt_chn_cod);
      end
    end
  endtask

  task automatic test_reset();
    hrst_b   = 1'b0;
    chn_trg  = '0;
    chn_en   = '0;
    grnt_ack = 1'b0;
    chn_done = 1'b0;
    step();
    step();
    testsRun++;
    if ({grnt_vld, busy, grnt_onehot, grnt_chn_cod, pend} !== 38'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_values: vld=%b busy=%b onehot=%h cod=%0d pend=%h, required all zero", grnt_vld, busy, grnt_onehot, grnt_chn_cod, pend);
    end
    hrst_b = 1'b1;
    step();
  endtask

  task automatic test_single();
    chn_en  = 16'hFFFF;
    chn_trg = 16'h0008;
    expQ.push_back(3);
    step();
    chn_trg = '0;
    testsRun++;
    if (pend !== 16'h0008 || grnt_vld !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL single_pend: pend=%h vld=%b, required 0008 0", pend, grnt_vld);
    end
    step();
    testsRun++;
    if (grnt_vld !== 1'b1 || grnt_onehot !== 16'h0008 || grnt_chn_cod !== 4'd3) begin
      testsFailed++;
      $display("[TB] FAIL single_latency: vld=%b onehot=%h cod=%0d, required 1 0008 3", grnt_vld, grnt_onehot, grnt_chn_cod);
    end
    drain_grants(1, "single");
    testsRun++;
    if (pend !== 16'h0) begin
      testsFailed++;
      $display("[TB] FAIL single_pend_clr: pend=%h, required 0000", pend);
    end
  endtask

  task automatic test_order();
    chn_trg = 16'hA050;
    expQ.push_back(4);
    expQ.push_back(6);
    expQ.push_back(13);
    expQ.push_back(15);
    step();
    chn_trg = '0;
    drain_grants(4, "order");
    testsRun++;
    if (pend !== 16'h0) begin
      testsFailed++;
      $display("[TB] FAIL order_pend_clr: pend=%h, required 0000", pend);
    end
  endtask

  task automatic test_no_preempt();
    chn_trg = 16'h0040;
    step();
    chn_trg = '0;
    step();
    testsRun++;
    if (grnt_vld !== 1'b1 || grnt_chn_cod !== 4'd6) begin
      testsFailed++;
      $display("[TB] FAIL nopre_grant6: vld=%b cod=%0d, required 1 6", grnt_vld, grnt_chn_cod);
    end
    grnt_ack = 1'b1;
    step();
    grnt_ack = 1'b0;
    chn_trg = 16'h0002;
    step();
    chn_trg = '0;
    step();
    testsRun++;
    if (busy !== 1'b1 || grnt_vld !== 1'b0 || grnt_onehot !== 16'h0040 || grnt_chn_cod !== 4'd6 || pend !== 16'h0042) begin
      testsFailed++;
      $display("[TB] FAIL nopre_hold: busy=%b vld=%b onehot=%h cod=%0d pend=%h, required 1 0 0040 6 0042", busy, grnt_vld, grnt_onehot, grnt_chn_cod, pend);
    end
    chn_done = 1'b1;
    step();
    chn_done = 1'b0;
    testsRun++;
    if (busy !== 1'b0 || grnt_onehot !== 16'h0 || pend !== 16'h0002) begin
      testsFailed++;
      $display("[TB] FAIL nopre_done: busy=%b onehot=%h pend=%h, required 0 0000 0002", busy, grnt_onehot, pend);
    end
    expQ.push_back(1);
    drain_grants(1, "nopre");
  endtask

  task automatic test_back_to_back();
    chn_trg = 16'h0004;
    step();
    chn_trg = '0;
    step();
    testsRun++;
    if (grnt_vld !== 1'b1 || grnt_chn_cod !== 4'd2) begin
      testsFailed++;
      $display("[TB] FAIL b2b_grant: vld=%b cod=%0d, required 1 2", grnt_vld, grnt_chn_cod);
    end
    grnt_ack = 1'b1;
    step();
    grnt_ack = 1'b0;
    chn_done = 1'b1;
    chn_trg  = 16'h0004;
    step();
    chn_done = 1'b0;
    chn_trg  = '0;
    testsRun++;
    if (pend !== 16'h0004 || busy !== 1'b0 || grnt_vld !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_retrig: pend=%h busy=%b vld=%b, required 0004 0 0", pend, busy, grnt_vld);
    end
    step();
    testsRun++;
    if (grnt_vld !== 1'b1 || grnt_chn_cod !== 4'd2 || grnt_onehot !== 16'h0004) begin
      testsFailed++;
      $display("[TB] FAIL b2b_regrant: vld=%b cod=%0d onehot=%h, required 1 2 0004", grnt_vld, grnt_chn_cod, grnt_onehot);
    end
    expQ.push_back(2);
    drain_grants(1, "b2b");
  endtask

  task automatic test_withdraw();
    chn_trg = 16'h0120;
    step();
    chn_trg = '0;
    step();
    testsRun++;
    if (grnt_vld !== 1'b1 || grnt_chn_cod !== 4'd5) begin
      testsFailed++;
      $display("[TB] FAIL withdraw_grant5: vld=%b cod=%0d, required 1 5", grnt_vld, grnt_chn_cod);
    end
    chn_en   = 16'hFFDF;
    grnt_ack = 1'b1;
    step();
    chn_en   = 16'hFFFF;
    grnt_ack = 1'b0;
    testsRun++;
    if (grnt_vld !== 1'b0 || busy !== 1'b0 || pend !== 16'h0100 || grnt_onehot !== 16'h0) begin
      testsFailed++;
      $display("[TB] FAIL withdraw_drop: vld=%b busy=%b pend=%h onehot=%h, required 0 0 0100 0000", grnt_vld, busy, pend, grnt_onehot);
    end
    expQ.push_back(8);
    drain_grants(1, "withdraw");
  endtask

  task automatic test_reset_busy();
    chn_trg = 16'h0300;
    step();
    chn_trg = '0;
    step();
    grnt_ack = 1'b1;
    step();
    grnt_ack = 1'b0;
    testsRun++;
    if (busy !== 1'b1 || grnt_chn_cod !== 4'd8 || pend !== 16'h0300) begin
      testsFailed++;
      $display("[TB] FAIL rstbusy_setup: busy=%b cod=%0d pend=%h, required 1 8 0300", busy, grnt_chn_cod, pend);
    end
    #2;
    hrst_b = 1'b0;
    #1;
    testsRun++;
    if ({grnt_vld, busy, grnt_onehot, grnt_chn_cod, pend} !== 38'd0) begin
      testsFailed++;
      $display("[TB] FAIL rstbusy_async: vld=%b busy=%b onehot=%h cod=%0d pend=%h, required all zero", grnt_vld, busy, grnt_onehot, grnt_chn_cod, pend);
    end
    for (int c = 0; c < 4; c++) begin
      grnt_ack = 1'($urandom_range(0, 1));
      chn_done = 1'($urandom_range(0, 1));
      step();
    end
    testsRun++;
    if ({grnt_vld, busy, grnt_onehot, pend} !== 34'd0) begin
      testsFailed++;
      $display("[TB] FAIL rstbusy_held: vld=%b busy=%b onehot=%h pend=%h, required all zero", grnt_vld, busy, grnt_onehot, pend);
    end
    hrst_b   = 1'b1;
    grnt_ack = 1'b0;
    chn_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      testsRun++;
      if (grnt_vld !== 1'b0 || pend !== 16'h0) begin
        testsFailed++;
        $display("[TB] FAIL rstbusy_quiet: cycle %0d vld=%b pend=%h, required 0 0000", c, grnt_vld, pend);
      end
    end
  endtask

  // Overall guard so a stuck design still ends the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", testsRun, testsFailed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_order();
    test_no_preempt();
    test_back_to_back();
    test_withdraw();
    test_reset_busy();
    testsRun++;
    if (expQ.size() !== 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_empty: %0d grants outstanding, required 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/hpchn_arb.md
# hpchn_arb

Sequential channel arbiter for the DMA high-priority channel path. It collects per-channel trigger pulses into a pending register and selects the lowest-numbered pending, enabled channel. It presents that channel to the DMA transfer engine as a one-hot grant plus a binary channel code, and holds the grant under a valid/ack handshake until the engine reports completion. It sits between the channel trigger sources and the transfer engine's channel mux.

## Interface
Parameters:
- CHN_NUM, 16, number of channels; fixed at 16 in this design.
- CHN_MUX_W, 4, width of the binary channel code; equals log2(CHN_NUM).

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- hclk, input, 1, system clock; all state updates on the rising edge.
- hrst_b, input, 1, asynchronous active-low reset.
- chn_trg, input, CHN_NUM, per-channel trigger; sampled every cycle, so a level is treated as a repeated pulse.
- chn_en, input, CHN_NUM, per-channel enable mask.
- grnt_ack, input, 1, engine accepts the presented grant.
- chn_done, input, 1, engine finished the transfer for the granted channel; single-cycle pulse.
- grnt_vld, output, 1, grant valid.
- grnt_onehot, output, CHN_NUM, one-hot granted channel; zero when no grant is held.
- grnt_chn_cod, output, CHN_MUX_W, binary index of the granted channel.
- pend, output, CHN_NUM, pending-request register.
- busy, output, 1, grant accepted and transfer in progress.

## Operation
Pending register, per bit i:
- Set when chn_trg[i] & chn_en[i].
- Cleared when chn_done is seen in BUSY and i is the granted channel.
- Cleared when chn_en[i] is low, except for the granted channel while in BUSY.
- Set wins over clear in the same cycle, so a re-trigger during chn_done leaves the bit pending.

Selection:
- Lowest set bit of the registered pend, computed as pend & (~pend + 1).
- Incoming triggers never bypass pend.

State machine: IDLE, REQ, BUSY.
- IDLE: if pend != 0, register the one-hot selection and its binary code, then go to REQ. Otherwise stay in IDLE.
- REQ: grnt_vld = 1. Grant outputs stay frozen; a newly pending lower channel does not preempt.
  - grnt_ack = 1 → go to BUSY.
  - Granted channel's chn_en drops before ack → withdraw the grant (grnt_vld low next cycle), clear its pend bit, go to IDLE.
  - An ack in the same cycle as the disable is ignored; withdrawal wins.
- BUSY: busy = 1, grnt_vld = 0. grnt_onehot and grnt_chn_cod are held.
  - chn_done → clear the granted pend bit (unless re-triggered), zero the grant outputs, go to IDLE.
  - Disabling the granted channel in BUSY has no effect; the transfer completes.
- chn_done outside BUSY and grnt_ack outside REQ are ignored.

## Timing
- Reset values: state IDLE, pend = 0, grnt_vld = 0, grnt_onehot = 0, grnt_chn_cod = 0, busy = 0.
- Reset asserted mid-operation drops every grant and pending bit immediately, with no handshake.
- Trigger to grant: trigger high in cycle t → pend bit visible in t+1 → grnt_vld and grant outputs visible in t+2.
- Ack: grnt_ack sampled high in cycle a → grnt_vld low and busy high in a+1. Ack may arrive in the first grnt_vld cycle.
- Done: chn_done sampled in cycle d → busy low and grant outputs zero in d+1 (IDLE). The next grant is visible no earlier than d+2.
- Every output is driven directly from a register; no combinational path runs from any input to any output.

## Structure
- Package hpchn_pkg holds:
  - the CHN_NUM and CHN_MUX_W constants;
  - the state encoding: IDLE = 2'b00, REQ = 2'b01, BUSY = 2'b10.
- One sub-module, hpchn_encd: purely combinational CHN_NUM one-hot to CHN_MUX_W binary encoder, built as an OR-reduction per code bit.
  - An all-zero input gives code 0.
  - Instantiated once, driven by the selection, and its result is registered in IDLE.
- Lowest-set isolation is inline in hpchn_arb.

## Test plan
- Reset, then chn_en = 16'hFFFF and chn_trg = 16'h0008 for one cycle → pend = 16'h0008 at t+1; grnt_vld = 1, grnt_onehot = 16'h0008, grnt_chn_cod = 3 at t+2. Ack gives busy = 1; done returns to IDLE with pend = 0.
- chn_trg = 16'hA050 in one cycle, then ack/done each grant → grants in order 4, 6, 13, 15, each separated by at least one IDLE cycle.
- While BUSY on channel 6, trigger channel 1 → no preemption. After done on channel 6, the next grant is channel 1.
- chn_done and chn_trg for the granted channel 2 in the same cycle → pend[2] stays set, and channel 2 is granted again two cycles later.
- In REQ for channel 5 with no ack, drop chn_en[5] → grnt_vld low next cycle and pend[5] = 0. Return to IDLE, then grant the next pending channel.
- Assert hrst_b low during BUSY, with chn_done and grnt_ack asserted randomly → all outputs zero immediately. After reset release, no grant appears without a new trigger.
